// File: rtl/memoria_instrucoes_param_if.sv
// Fetch/loader bus of the instruction memory.
// The master side is the fetch stage or program loader; the slave side is the memory.
interface memoria_instrucoes_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              Req;
    logic              Wren;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] Din;
    logic              Ready;
    logic              Busy;
    logic [DATA_W-1:0] Q;
    logic              Q_valid;

    modport master (
        output Req, Wren, Address, Din,
        input  Ready, Busy, Q, Q_valid
    );

    modport slave (
        input  Req, Wren, Address, Din,
        output Ready, Busy, Q, Q_valid
    );
endinterface

// File: rtl/memoria_instrucoes_param.sv
// Parametrised instruction memory: one synchronous read/write port and a
// request/valid handshake. The array itself has no reset, so after every reset
// an INIT sweep rewrites each word (boot program or zeros) before accesses open.
module memoria_instrucoes_param #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 4,
    parameter bit PRELOAD_EN = 1'b1
) (
    input logic                       Clock,
    input logic                       Reset,
    memoria_instrucoes_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // Boot program: ADD R1 R2 R3 ; SUB R1 R2 R3, zero-extended to the word width
    localparam logic [DATA_W-1:0] BOOT0 = DATA_W'(16'h0298);
    localparam logic [DATA_W-1:0] BOOT1 = DATA_W'(16'h1298);

    typedef enum logic {INIT, IDLE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] init_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] init_word;
    logic              acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // State register; the sweep pointer advances only during INIT and wraps to 0 on exit
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state <= state_next;
            if (state == INIT)
                init_ptr <= init_ptr + 1'b1;
        end
    end

    // Next state: leave INIT on the edge that writes the last word
    always_comb begin
        state_next = state;
        if (state == INIT && init_ptr == LAST_ADDR)
            state_next = IDLE;
    end

    // Value the sweep writes at the current pointer
    always_comb begin
        init_word = '0;
        if (PRELOAD_EN) begin
            if (init_ptr == ADDR_W'(0))
                init_word = BOOT0;
            else if (init_ptr == ADDR_W'(1))
                init_word = BOOT1;
        end
    end

    // Outputs and write-port steering: the sweep owns the port in INIT, the bus in IDLE
    always_comb begin
        bus.Ready = (state == IDLE);
        bus.Busy  = (state != IDLE);
        acc       = (state == IDLE) && bus.Req;
        mem_we    = 1'b0;
        mem_waddr = init_ptr;
        mem_wdata = init_word;
        if (state == INIT) begin
            mem_we = 1'b1;
        end else if (acc && bus.Wren) begin
            mem_we    = 1'b1;
            mem_waddr = bus.Address;
            mem_wdata = bus.Din;
        end
    end

    // Memory array: no reset, contents established by the sweep
    always_ff @(posedge Clock) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    // Read/write-through data register; Q holds between accesses, Q_valid pulses per access
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bus.Q       <= '0;
            bus.Q_valid <= 1'b0;
        end else begin
            bus.Q_valid <= acc;
            if (acc)
                bus.Q <= bus.Wren ? bus.Din : mem[bus.Address];
        end
    end
endmodule

// File: tb/tb_memoria_instrucoes_param.sv
// Bench for memoria_instrucoes_param: a default 16x16 preloaded instance driven
// through a scoreboard, plus a 64x32 zero-initialised instance.
module tb_memoria_instrucoes_param;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    logic rst_b = 1'b1;
    int   cyc   = 0;
    int   nvec  = 0;
    int   nerr  = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc = cyc + 1;

    memoria_instrucoes_param_if #(.DATA_W(16), .ADDR_W(4)) bus ();
    memoria_instrucoes_param_if #(.DATA_W(32), .ADDR_W(6)) bus_b ();

    memoria_instrucoes_param #(.DATA_W(16), .ADDR_W(4), .PRELOAD_EN(1'b1)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus)
    );
    memoria_instrucoes_param #(.DATA_W(32), .ADDR_W(6), .PRELOAD_EN(1'b0)) dut_b (
        .Clock(Clock), .Reset(rst_b), .bus(bus_b)
    );

    typedef struct {
        logic [15:0] q;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl [16];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic mdl_boot();
        foreach (mdl[i]) mdl[i] = 16'h0000;
        mdl[0] = 16'h0298;
        mdl[1] = 16'h1298;
    endtask

    // Called just after a negedge; the access is taken on the next posedge
    task automatic access(input logic wr, input logic [3:0] a, input logic [15:0] d);
        exp_t e;
        bus.Req = 1'b1; bus.Wren = wr; bus.Address = a; bus.Din = d;
        e.cyc = cyc + 1;
        if (wr) begin
            mdl[a] = d;
            e.q = d;
        end else begin
            e.q = mdl[a];
        end
        sb.push_back(e);
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        bus.Req = 1'b0; bus.Wren = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    // Counts posedges from now until Ready; bounded so a stuck INIT still ends the run
    task automatic wait_ready(input string tag, input int exp_edges, input bit use_b);
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge Clock);
            n++;
            if (use_b ? bus_b.Ready : bus.Ready) break;
        end
        chk(tag, 64'(n), 64'(exp_edges));
    endtask

    // Scoreboard monitor: every Q_valid must match the oldest expectation, in its cycle
    always @(negedge Clock) begin
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            chk("qv_missing", 64'(cyc), 64'(sb[0].cyc));
            void'(sb.pop_front());
        end
        if (bus.Q_valid) begin
            if (sb.size() == 0) begin
                chk("qv_unexpected", 64'(bus.Q_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("q", 64'(bus.Q), 64'(e.q));
                chk("q_cyc", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        logic [15:0] last_q;
        bus.Req = 1'b0; bus.Wren = 1'b0; bus.Address = '0; bus.Din = '0;
        bus_b.Req = 1'b0; bus_b.Wren = 1'b0; bus_b.Address = '0; bus_b.Din = '0;
        mdl_boot();

        // 1. reset defaults, INIT length, requests ignored during INIT
        repeat (2) @(negedge Clock);
        chk("rst_q", 64'(bus.Q), 64'(0));
        chk("rst_qv", 64'(bus.Q_valid), 64'(0));
        chk("rst_busy", 64'(bus.Busy), 64'(1));
        chk("rst_ready", 64'(bus.Ready), 64'(0));
        Reset = 1'b0;
        bus.Req = 1'b1; bus.Wren = 1'b1; bus.Address = 4'd5; bus.Din = 16'hFFFF;
        wait_ready("init_edges", 16, 1'b0);
        chk("idle_busy", 64'(bus.Busy), 64'(0));
        idle(1);

        // 2. boot program read back-to-back (addr 5 proves the INIT write was dropped)
        access(1'b0, 4'd0, 16'h0);
        access(1'b0, 4'd1, 16'h0);
        access(1'b0, 4'd2, 16'h0);
        access(1'b0, 4'd5, 16'h0);
        idle(2);

        // 3. write-through then read-after-write
        access(1'b1, 4'd15, 16'hBEEF);
        access(1'b0, 4'd15, 16'h0);
        // 4. Q holds with Req low
        last_q = 16'hBEEF;
        repeat (3) begin
            idle(1);
            chk("hold_q", 64'(bus.Q), 64'(last_q));
            chk("hold_qv", 64'(bus.Q_valid), 64'(0));
        end
        // Wren without Req must not write
        bus.Req = 1'b0; bus.Wren = 1'b1; bus.Address = 4'd3; bus.Din = 16'h7777;
        @(negedge Clock);
        access(1'b0, 4'd3, 16'h0);
        // a few mixed back-to-back accesses
        for (int i = 0; i < 6; i++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            access(i[0], a, 16'($urandom));
        end
        idle(2);

        // 5a. reset during INIT at pointer 7
        Reset = 1'b1; @(negedge Clock); Reset = 1'b0;
        repeat (7) @(negedge Clock);
        Reset = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(bus.Busy), 64'(1));
        chk("mid_rst_q", 64'(bus.Q), 64'(0));
        @(negedge Clock);
        Reset = 1'b0;
        wait_ready("reinit_edges", 16, 1'b0);
        mdl_boot();
        idle(1);
        access(1'b0, 4'd0, 16'h0);

        // 5b. loader write, reset in IDLE, the sweep wipes it
        access(1'b1, 4'd2, 16'h1234);
        access(1'b0, 4'd2, 16'h0);
        idle(2);
        Reset = 1'b1; @(negedge Clock);
        chk("idle_rst_q", 64'(bus.Q), 64'(0));
        Reset = 1'b0;
        wait_ready("reinit2_edges", 16, 1'b0);
        mdl_boot();
        idle(1);
        access(1'b0, 4'd2, 16'h0);
        access(1'b0, 4'd1, 16'h0);
        idle(3);

        // 6. 64 x 32 instance without preload
        rst_b = 1'b0;
        wait_ready("b_init_edges", 64, 1'b1);
        for (int a = 0; a < 64; a++) begin
            bus_b.Req = 1'b1; bus_b.Wren = 1'b0; bus_b.Address = 6'(a);
            @(negedge Clock);
            if (bus_b.Q_valid !== 1'b1 || bus_b.Q !== 32'h0)
                chk($sformatf("b_rd%0d", a), {bus_b.Q_valid, bus_b.Q}, {1'b1, 32'h0});
            else
                nvec++;
        end
        bus_b.Wren = 1'b1; bus_b.Address = 6'd63; bus_b.Din = 32'hDEADBEEF;
        @(negedge Clock);
        chk("b_wr_q", 64'(bus_b.Q), 64'(32'hDEADBEEF));
        bus_b.Wren = 1'b0; bus_b.Din = 32'h0;
        @(negedge Clock);
        chk("b_rd_q", 64'(bus_b.Q), 64'(32'hDEADBEEF));
        chk("b_rd_qv", 64'(bus_b.Q_valid), 64'(1));
        bus_b.Req = 1'b0;
        @(negedge Clock);
        chk("b_idle_qv", 64'(bus_b.Q_valid), 64'(0));

        chk("sb_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
